led_run_scheduler: RTL and testbench
====================================

Name: led_run_scheduler

Overview:
- Shares one LED counter bank between two requesters, typically the icestick buttons after inversion and debounce.
- A round-robin arbiter grants the bank to one requester at a time.
- Requester 0 runs an up-count (0 to MAX_COUNT). Requester 1 runs a down-count (MAX_COUNT to 0).
- A clock-enable tick paces each run. There is no derived clock: everything is in the clk domain.

Parameters:
- TICK_DIV, 24'd1500000: clk cycles per LED step. Legal range 1..2^24-1.
- LED_W, 4: LED bank width.
- MAX_COUNT, 15: end value of an up-run and start value of a down-run. Must be < 2^LED_W.

Ports:
- clk, input, 1: system clock; all state updates on its rising edge.
- rst, input, 1: synchronous, active-high reset.
- req, input, 2: level requests, active-high; bit i belongs to requester i. Already synchronised upstream.
- led, output, LED_W: shared LED bank value (registered).
- grant, output, 2: one-hot owner of the bank; 2'b00 when unowned (registered).
- busy, output, 1: high in RUN and DONE (registered or decoded from state).
- done, output, 2: one-cycle pulse on the bit of the requester whose run just finished.

Behaviour:
- One clock; reset is synchronous and active-high. Synchronous rst has priority over all other logic.
- Reset values: state=IDLE, led=0, grant=2'b00, done=2'b00, busy=0, tick_cnt=0, last=1. With last=1, requester 0 wins the first tie.
- States: IDLE, RUN, DONE. Encodings outside these three go to IDLE on the next cycle, with outputs forced to reset values.
- IDLE:
  - led=0, grant=0.
  - req=2'b00: stay in IDLE.
  - Exactly one req bit set: grant that bit.
  - req=2'b11: grant the bit != last.
  - On grant, next cycle: state=RUN, grant=one-hot winner, tick_cnt=0, led=0 (winner 0) or MAX_COUNT (winner 1).
  - Latency: req sampled high in cycle N, so grant and busy are high in cycle N+1.
- RUN:
  - tick_cnt increments each cycle. When tick_cnt==TICK_DIV-1, tick=1 for that cycle and tick_cnt wraps to 0.
  - On tick, if led==end value (MAX_COUNT for an up-run, 0 for a down-run): go to DONE, led holds.
  - Otherwise on tick: led+1 for an up-run, led-1 for a down-run. No wrap-around can occur.
  - req changes during RUN are ignored. Once granted, a run always completes. The other requester's req stays pending.
- Run duration: exactly (MAX_COUNT+1)*TICK_DIV cycles in RUN.
- DONE, one cycle:
  - done[owner]=1, last=owner, grant still asserted, led holds its end value.
  - Next state is IDLE: led=0, grant=0, done=0.
- Fairness: one cycle of IDLE always separates runs.
  - If req=2'b11 is held, grants alternate 0,1,0,1...
  - A single held req is re-served back-to-back, with one IDLE cycle between runs.
- TICK_DIV=1: tick every RUN cycle, so led changes every cycle.
- Reset during RUN or DONE: the next cycle is at reset values. No done pulse is generated for the aborted run.
- Widths: tick_cnt is 24 bits; led arithmetic is LED_W bits and unsigned.

Test Plan:
All scenarios use TICK_DIV=4, MAX_COUNT=3, LED_W=4.
1. Reset, then req=01 held for 1 cycle → grant=01 next cycle. led=0,1,2,3 with each step 4 cycles apart. DONE after 16 RUN cycles: done=01 for exactly 1 cycle, then led=0, grant=00, busy=0.
2. req=10 → led loads 3 at grant, steps 3,2,1,0 every 4 cycles. done=10 pulse after 16 RUN cycles.
3. req=11 held continuously from reset → grants alternate 01,10,01. Each run is 16 RUN cycles plus 1 DONE cycle plus 1 IDLE cycle, giving an 18-cycle period. done bits alternate.
4. Requester 0 running; req[1] asserts mid-run and req[0] drops → run 0 completes unchanged (led reaches 3, done=01). Requester 1 is granted in the cycle after the following IDLE cycle.
5. rst asserted for 1 cycle while led=2 in RUN → next cycle all outputs at reset values and no done pulse. With req=11 afterwards, requester 0 is granted first.
6. TICK_DIV=1, req=01 → led 0,1,2,3 on consecutive cycles. RUN lasts 4 cycles, then a single-cycle done=01.

Source files
------------

// File: rtl/led_run_scheduler.sv
`default_nettype none
// ----------------------------------------------------------------------------
// led_run_scheduler: round-robin sharing of one LED counter bank, up/down runs
// Revision: 1.0
// ----------------------------------------------------------------------------
module led_run_scheduler #(
    parameter logic [23:0] TICK_DIV  = 24'd1500000,
    parameter int          LED_W     = 4,
    parameter int          MAX_COUNT = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       req,
    output logic [LED_W-1:0] led,
    output logic [1:0]       grant,
    output logic             busy,
    output logic [1:0]       done
);

    localparam logic [LED_W-1:0] MAX_VAL   = LED_W'(MAX_COUNT);
    localparam logic [23:0]      TICK_LAST = TICK_DIV - 24'd1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [LED_W-1:0] led_nxt;
    logic [1:0]       grant_nxt;
    logic [1:0]       done_nxt;
    logic             last, last_nxt;
    logic [23:0]      tick_cnt, tick_nxt;
    logic             tick;
    logic             at_end;

    always_comb begin
        state_nxt = state;
        led_nxt   = led;
        grant_nxt = grant;
        done_nxt  = 2'b00;
        last_nxt  = last;
        tick_nxt  = tick_cnt;
        tick      = (tick_cnt == TICK_LAST);
        // grant[1] marks a down-run, which ends at zero
        at_end    = grant[1] ? (led == '0) : (led == MAX_VAL);

        case (state)
            IDLE: begin
                led_nxt   = '0;
                grant_nxt = 2'b00;
                tick_nxt  = '0;
                if (req != 2'b00) begin
                    state_nxt = RUN;
                    if (req == 2'b11)
                        grant_nxt = last ? 2'b01 : 2'b10;
                    else
                        grant_nxt = req;
                    led_nxt = grant_nxt[1] ? MAX_VAL : '0;
                end
            end
            RUN: begin
                tick_nxt = tick ? 24'd0 : tick_cnt + 24'd1;
                if (tick) begin
                    if (at_end) begin
                        state_nxt = DONE;
                        done_nxt  = grant;
                    end else begin
                        led_nxt = grant[1] ? led - LED_W'(1) : led + LED_W'(1);
                    end
                end
            end
            DONE: begin
                state_nxt = IDLE;
                led_nxt   = '0;
                grant_nxt = 2'b00;
                last_nxt  = grant[1];
            end
            default: begin
                state_nxt = IDLE;
                led_nxt   = '0;
                grant_nxt = 2'b00;
                last_nxt  = 1'b1;
                tick_nxt  = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            led      <= '0;
            grant    <= 2'b00;
            done     <= 2'b00;
            last     <= 1'b1;
            tick_cnt <= '0;
        end else begin
            state    <= state_nxt;
            led      <= led_nxt;
            grant    <= grant_nxt;
            done     <= done_nxt;
            last     <= last_nxt;
            tick_cnt <= tick_nxt;
        end
    end

    assign busy = (state == RUN) || (state == DONE);

endmodule
`default_nettype wire

// File: tb/tb_led_run_scheduler.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_led_run_scheduler: directed bench, TICK_DIV=4 and TICK_DIV=1 instances
// Revision: 1.0
// ----------------------------------------------------------------------------
module tb_led_run_scheduler;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] req = 2'b00;
    logic [1:0] req2 = 2'b00;
    logic [3:0] led, led2;
    logic [1:0] grant, grant2, done, done2;
    logic       busy, busy2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    led_run_scheduler #(.TICK_DIV(24'd4), .LED_W(4), .MAX_COUNT(3)) dut (
        .clk(clk), .rst(rst), .req(req),
        .led(led), .grant(grant), .busy(busy), .done(done)
    );

    led_run_scheduler #(.TICK_DIV(24'd1), .LED_W(4), .MAX_COUNT(3)) dut_fast (
        .clk(clk), .rst(rst), .req(req2),
        .led(led2), .grant(grant2), .busy(busy2), .done(done2)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        // reset
        step();
        step();
        chk("rst_led", 32'(led), 32'd0);
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);

        // scenario 1: up-run for requester 0
        rst = 1'b0;
        req = 2'b01;
        step();
        req = 2'b00;
        chk("s1_grant", 32'(grant), 32'd1);
        chk("s1_busy", 32'(busy), 32'd1);
        for (int k = 1; k <= 16; k++) begin
            chk("s1_led", 32'(led), 32'((k - 1) / 4));
            chk("s1_done_low", 32'(done), 32'd0);
            step();
        end
        chk("s1_done", 32'(done), 32'd1);
        chk("s1_done_led", 32'(led), 32'd3);
        chk("s1_done_grant", 32'(grant), 32'd1);
        step();
        chk("s1_idle_led", 32'(led), 32'd0);
        chk("s1_idle_grant", 32'(grant), 32'd0);
        chk("s1_idle_busy", 32'(busy), 32'd0);
        chk("s1_idle_done", 32'(done), 32'd0);

        // scenario 2: down-run for requester 1
        req = 2'b10;
        step();
        req = 2'b00;
        chk("s2_grant", 32'(grant), 32'd2);
        for (int k = 1; k <= 16; k++) begin
            chk("s2_led", 32'(led), 32'(3 - (k - 1) / 4));
            step();
        end
        chk("s2_done", 32'(done), 32'd2);
        chk("s2_done_led", 32'(led), 32'd0);
        step();
        chk("s2_idle_done", 32'(done), 32'd0);
        chk("s2_idle_busy", 32'(busy), 32'd0);

        // scenario 3: req=11 held from reset, alternating grants
        rst = 1'b1;
        req = 2'b11;
        step();
        rst = 1'b0;
        step();
        for (int r = 0; r < 3; r++) begin
            chk("s3_grant", 32'(grant), (r % 2 == 0) ? 32'd1 : 32'd2);
            chk("s3_led0", 32'(led), (r % 2 == 0) ? 32'd0 : 32'd3);
            repeat (16) step();
            chk("s3_done", 32'(done), (r % 2 == 0) ? 32'd1 : 32'd2);
            step();
            chk("s3_idle_grant", 32'(grant), 32'd0);
            chk("s3_idle_busy", 32'(busy), 32'd0);
            if (r < 2) step();
        end

        // scenario 4: requester switch mid-run is ignored until completion
        req = 2'b01;
        step();
        chk("s4_grant", 32'(grant), 32'd1);
        for (int k = 1; k <= 16; k++) begin
            chk("s4_led", 32'(led), 32'((k - 1) / 4));
            chk("s4_grant_hold", 32'(grant), 32'd1);
            if (k == 6) req = 2'b10;
            step();
        end
        chk("s4_done", 32'(done), 32'd1);
        chk("s4_done_led", 32'(led), 32'd3);
        step();
        chk("s4_idle_grant", 32'(grant), 32'd0);
        step();
        chk("s4_grant1", 32'(grant), 32'd2);
        chk("s4_led1", 32'(led), 32'd3);

        // scenario 5: reset mid-run aborts without a done pulse
        req = 2'b00;
        repeat (4) step();
        chk("s5_led_pre", 32'(led), 32'd2);
        rst = 1'b1;
        req = 2'b11;
        step();
        chk("s5_rst_led", 32'(led), 32'd0);
        chk("s5_rst_grant", 32'(grant), 32'd0);
        chk("s5_rst_busy", 32'(busy), 32'd0);
        chk("s5_rst_done", 32'(done), 32'd0);
        rst = 1'b0;
        step();
        chk("s5_first_grant", 32'(grant), 32'd1);
        chk("s5_no_done", 32'(done), 32'd0);

        // scenario 6: TICK_DIV=1 steps every cycle
        rst = 1'b1;
        req = 2'b00;
        step();
        rst = 1'b0;
        req2 = 2'b01;
        step();
        req2 = 2'b00;
        chk("s6_grant", 32'(grant2), 32'd1);
        for (int k = 1; k <= 4; k++) begin
            chk("s6_led", 32'(led2), 32'(k - 1));
            chk("s6_busy", 32'(busy2), 32'd1);
            step();
        end
        chk("s6_done", 32'(done2), 32'd1);
        chk("s6_done_led", 32'(led2), 32'd3);
        step();
        chk("s6_idle_done", 32'(done2), 32'd0);
        chk("s6_idle_grant", 32'(grant2), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
